// File: rtl/risc_v_mike_pkg.sv
// Shared types and defaults for the risc_v_mike instruction fetch path.
package risc_v_mike_pkg;

  typedef logic [31:0] t_pc_addr;

  localparam t_pc_addr RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } t_fetch_state;

endpackage

// File: rtl/risc_v_mike_sync_fifo.sv
// Single-clock FIFO with synchronous flush; simultaneous push/pop allowed at any occupancy.
module risc_v_mike_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (count == '0);
    full     = (count == (AW+1)'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch unit: credit-limited request stream, in-order response buffer, redirect flush.
module risc_v_mike_fetch_unit
  import risc_v_mike_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INSTR_W    = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_val,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          imem_req_val,
  output logic [ADDR_W-1:0]             imem_req_addr,
  input  logic                          imem_req_rdy,
  input  logic                          imem_rsp_val,
  input  logic [INSTR_W-1:0]            imem_rsp_data,
  output logic                          fetch_val,
  output logic [INSTR_W-1:0]            fetch_instr,
  output logic [ADDR_W-1:0]             fetch_pc,
  input  logic                          fetch_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fetch_count
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  t_fetch_state      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic               req_val, req_fire, rsp_fire, rsp_keep, fifo_pop;
  logic [ADDR_W-1:0]  redirect_aligned;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_empty;
  logic               fifo_full_unused;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_aligned     = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_comb begin
    // Credit: every in-flight response already owns a buffer slot.
    req_val  = (state_q != IDLE) && !redirect_val &&
               (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH));
    req_fire = req_val & imem_req_rdy;
    rsp_fire = imem_rsp_val && (outstanding_q != '0);
    rsp_keep = rsp_fire && (drop_cnt_q == '0) && !redirect_val;
    fifo_pop = fetch_val & fetch_rdy & !redirect_val;

    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    if (redirect_val) begin
      fetch_addr_d = redirect_aligned;
      rsp_pc_d     = redirect_aligned;
      drop_cnt_d   = outstanding_q - CNT_W'(rsp_fire);
      state_d      = (drop_cnt_d != '0) ? FLUSH : RUN;
    end else begin
      if (req_fire) fetch_addr_d = fetch_addr_q + ADDR_W'(4);
      if (rsp_keep) rsp_pc_d     = rsp_pc_q + ADDR_W'(4);
      if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      case (state_q)
        IDLE:    state_d = RUN;
        FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_addr_q  <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  risc_v_mike_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_val),
    .push  (rsp_keep),
    .wdata ({rsp_pc_q, imem_rsp_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .count (fifo_count)
  );

  // Head fields are forced to zero when empty so stale storage never leaks out.
  always_comb begin
    imem_req_val  = req_val;
    imem_req_addr = fetch_addr_q;
    fetch_val     = ~fifo_empty;
    fetch_instr   = fetch_val ? fifo_rdata[INSTR_W-1:0] : '0;
    fetch_pc      = fetch_val ? fifo_rdata[ENTRY_W-1:INSTR_W] : '0;
    fetch_count   = fifo_count;
  end

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
// Scoreboard bench for risc_v_mike_fetch_unit with an in-order latency memory model.
module tb_risc_v_mike_fetch_unit;
  import risc_v_mike_pkg::*;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        imem_req_val;
  logic [31:0] imem_req_addr;
  logic        imem_req_rdy;
  logic        imem_rsp_val;
  logic [31:0] imem_rsp_data;
  logic        fetch_val;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_rdy;
  logic [2:0]  fetch_count;

  risc_v_mike_fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0040_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_val(redirect_val), .redirect_pc(redirect_pc),
    .imem_req_val(imem_req_val), .imem_req_addr(imem_req_addr), .imem_req_rdy(imem_req_rdy),
    .imem_rsp_val(imem_rsp_val), .imem_rsp_data(imem_rsp_data),
    .fetch_val(fetch_val), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_rdy(fetch_rdy), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  rsp_t        pend_q[$];
  logic [31:0] acc_log[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int          max_cnt = 0;
  logic [7:0]  gen = 8'd1;
  int          n_checks = 0, n_pass = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a, logic [7:0] g);
    return {g, 8'h5A, a[15:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_seq(logic [31:0] start, int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = mem_word(e.pc, gen);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(string name, int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin step(1); k++; end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(int hold, logic rdy_after, logic frdy_after);
    int k;
    rst = 1'b1; imem_req_rdy = 1'b0; fetch_rdy = 1'b0; redirect_val = 1'b0;
    step(hold);
    k = 0;
    while (pend_q.size() != 0 && k < 200) begin step(1); k++; end
    step(1);
    gen++;
    acc_log.delete();
    exp_q.delete();
    rst = 1'b0; imem_req_rdy = rdy_after; fetch_rdy = frdy_after;
  endtask

  // Memory: responses in order, each at least lat_min cycles after acceptance.
  initial begin
    rsp_t r;
    int   d;
    imem_rsp_val  = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      imem_rsp_val = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        imem_rsp_val  = 1'b1;
        imem_rsp_data = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      @(negedge clk);
      if (imem_req_val && imem_req_rdy) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        r.addr = imem_req_addr;
        r.data = mem_word(imem_req_addr, gen);
        r.due  = d;
        pend_q.push_back(r);
        acc_log.push_back(imem_req_addr);
      end
    end
  end

  // Monitor: every consumed instruction must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst && int'(fetch_count) > max_cnt) max_cnt = int'(fetch_count);
    if (!rst && fetch_val && fetch_rdy && !redirect_val) begin
      if (exp_q.size() == 0) begin
        check("fetch_unexpected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("fetch_pc", fetch_pc, mon_e.pc);
        check("fetch_instr", fetch_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; redirect_val = 1'b0; redirect_pc = '0; imem_req_rdy = 1'b0; fetch_rdy = 1'b0;
    step(2);
    check("rst_req_val", imem_req_val, 0);
    check("rst_req_addr", imem_req_addr, 32'h0040_0000);
    check("rst_fetch_val", fetch_val, 0);
    check("rst_fetch_instr", fetch_instr, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_fetch_count", fetch_count, 0);

    // Streaming, latency 1, always ready.
    expect_seq(32'h0040_0000, 8);
    rst = 1'b0; imem_req_rdy = 1'b1; fetch_rdy = 1'b1;
    k = 0;
    do begin step(1); k++; end while (!fetch_val && k < 10);
    check("first_fetch_latency", k, 3);
    wait_drain("stream", 60);
    fetch_rdy = 1'b0;
    check("req_addr0", acc_log[0], 32'h0040_0000);
    check("req_addr1", acc_log[1], 32'h0040_0004);
    check("req_addr2", acc_log[2], 32'h0040_0008);
    check("req_addr3", acc_log[3], 32'h0040_000C);

    // Decode stalled: credit stops requests at buffer depth.
    do_reset(2, 1'b1, 1'b0);
    step(15);
    check("stall_accepted", acc_log.size(), 4);
    check("stall_count", fetch_count, 4);
    check("stall_req_val", imem_req_val, 0);
    expect_seq(32'h0040_0000, 4);
    fetch_rdy = 1'b1;
    wait_drain("stall", 40);
    fetch_rdy = 1'b0;

    // Redirect with two outstanding requests.
    do_reset(2, 1'b1, 1'b0);
    lat_min = 4; lat_max = 4;
    k = 0;
    while (acc_log.size() < 2 && k < 20) begin step(1); k++; end
    imem_req_rdy = 1'b0;
    redirect_val = 1'b1; redirect_pc = 32'h0040_0103;
    @(negedge clk);
    check("redir_req_suppressed", imem_req_val, 0);
    @(posedge clk); #1;
    acc_log.delete();
    redirect_val = 1'b0;
    check("redir_state_flush", dut.state_q, FLUSH);
    check("redir_fetch_val", fetch_val, 0);
    expect_seq(32'h0040_0100, 4);
    imem_req_rdy = 1'b1; fetch_rdy = 1'b1;
    wait_drain("redir", 80);
    fetch_rdy = 1'b0;
    check("redir_first_req", acc_log[0], 32'h0040_0100);
    lat_min = 1; lat_max = 1;

    // Redirect coinciding with a response and a pop.
    do_reset(2, 1'b1, 1'b1);
    expect_seq(32'h0040_0000, 3);
    wait_drain("coinc_pre", 30);
    #1;
    check("coinc_rsp_val", imem_rsp_val, 1);
    check("coinc_fetch_val", fetch_val, 1);
    acc_log.delete();
    redirect_val = 1'b1; redirect_pc = 32'h0040_0200;
    @(negedge clk);
    check("coinc_req_suppressed", imem_req_val, 0);
    @(posedge clk); #1;
    redirect_val = 1'b0; fetch_rdy = 1'b0;
    check("coinc_fetch_val_after", fetch_val, 0);
    check("coinc_count_after", fetch_count, 0);
    check("coinc_state_run", dut.state_q, RUN);
    expect_seq(32'h0040_0200, 4);
    fetch_rdy = 1'b1;
    wait_drain("coinc", 40);
    fetch_rdy = 1'b0;
    check("coinc_first_req", acc_log[0], 32'h0040_0200);

    // Random memory handshake and latency.
    do_reset(2, 1'b0, 1'b0);
    lat_min = 1; lat_max = 5;
    max_cnt = 0;
    expect_seq(32'h0040_0000, 40);
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      imem_req_rdy = 1'($urandom_range(1, 0));
      fetch_rdy    = ($urandom_range(3, 0) != 0);
      step(1);
      k++;
    end
    fetch_rdy = 1'b0;
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_overflow", (max_cnt <= DEPTH), 1);
    exp_q.delete();

    // Reset with three requests in flight.
    do_reset(2, 1'b1, 1'b0);
    lat_min = 5; lat_max = 5;
    k = 0;
    while (acc_log.size() < 3 && k < 20) begin step(1); k++; end
    imem_req_rdy = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_req_val", imem_req_val, 0);
    check("midrst_req_addr", imem_req_addr, 32'h0040_0000);
    check("midrst_fetch_val", fetch_val, 0);
    check("midrst_fetch_count", fetch_count, 0);
    check("midrst_fetch_pc", fetch_pc, 0);
    gen++;
    step(1);
    rst = 1'b0;
    k = 0;
    while (pend_q.size() != 0 && k < 20) begin step(1); k++; end
    step(2);
    check("stale_fetch_count", fetch_count, 0);
    check("stale_fetch_val", fetch_val, 0);
    lat_min = 1; lat_max = 1;
    expect_seq(32'h0040_0000, 4);
    imem_req_rdy = 1'b1; fetch_rdy = 1'b1;
    wait_drain("post_rst", 40);
    fetch_rdy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
